// File: rtl/nios_2_switch_pkg.sv
// Shared definitions for the Nios II slide-switch conditioning slave:
// register word addresses and default build parameters.
package nios_2_switch_pkg;

    // Word addresses of the four slave registers
    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_EDGECAP = 2'd2,
        ADDR_RAW     = 2'd3
    } regAddr_e;

    // Number of switch lines on the board's switch bank
    localparam int DEFAULT_WIDTH = 5;

    // 1 ms of stability at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage : nios_2_switch_pkg

// File: rtl/nios_2_switch_debounce.sv
// One switch line: two-flop synchronizer followed by a counting debounce
// filter. The accepted level only changes after DEBOUNCE_CYCLES consecutive
// cycles of disagreement; edge_o pulses for the cycle in which it changes.
module nios_2_switch_debounce
    import nios_2_switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic raw_o,
    output logic level_o,
    output logic edge_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             edgePulse;

    // Bring the asynchronous switch line into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; any bounce back restarts from 0
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        edgePulse = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d  = sync2_q;
            cnt_d     = '0;
            edgePulse = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign raw_o   = sync2_q;
    assign level_o = stable_q;
    assign edge_o  = edgePulse;

endmodule : nios_2_switch_debounce

// File: rtl/nios_2_switch_ctrl.sv
// Avalon-MM slave replacing the bare switch PIO. Exposes the debounced
// level, the synchronized raw level, write-1-to-clear edge capture and a
// maskable level interrupt. Reads have a fixed latency of one clock.
module nios_2_switch_ctrl
    import nios_2_switch_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] rawLevel;
    logic [WIDTH-1:0] stableLevel;
    logic [WIDTH-1:0] edgePulse;

    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [WIDTH-1:0] w1cMask;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;

    logic             wrEn;
    logic             rdEn;
    logic             unusedWrData;

    assign wrEn = chipselect & ~write_n;
    assign rdEn = chipselect & write_n;

    // Only the low WIDTH bits of writedata carry register content
    assign unusedWrData = &{1'b0, writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            nios_2_switch_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .din_i   (in_port[gi]),
                .raw_o   (rawLevel[gi]),
                .level_o (stableLevel[gi]),
                .edge_o  (edgePulse[gi])
            );
        end
    endgenerate

    // Register-file updates; a fresh edge beats a simultaneous W1C clear
    always_comb begin
        irqMask_d = irqMask_q;
        w1cMask   = '0;
        if (wrEn && (address == ADDR_IRQMASK)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        if (wrEn && (address == ADDR_EDGECAP)) begin
            w1cMask = writedata[WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~w1cMask) | edgePulse;
        irq_d     = |(edgeCap_q & irqMask_q);
    end

    // Read mux; readdata holds its value when no read is in progress
    always_comb begin
        readdata_d = readdata_q;
        if (rdEn) begin
            case (address)
                ADDR_DATA:    readdata_d = 32'(stableLevel);
                ADDR_IRQMASK: readdata_d = 32'(irqMask_q);
                ADDR_EDGECAP: readdata_d = 32'(edgeCap_q);
                ADDR_RAW:     readdata_d = 32'(rawLevel);
                default:      readdata_d = '0;
            endcase
        end
    end

    // Slave state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q  <= '0;
            edgeCap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule : nios_2_switch_ctrl

// File: tb/tb_nios_2_switch_ctrl.sv
// Directed bench for nios_2_switch_ctrl with WIDTH=5, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nios_2_switch_ctrl;

    localparam int WIDTH = 5;
    localparam int DEB   = 4;

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_IRQMASK = 2'd1;
    localparam logic [1:0] A_EDGECAP = 2'd2;
    localparam logic [1:0] A_RAW     = 2'd3;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int errors = 0;
    int checks = 0;

    nios_2_switch_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] sw);
        in_port = sw;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readCheck(input logic [1:0] a, input logic [31:0] expected,
                             input string tag);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        checkOutput(tag, readdata, expected);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset state
        tick();
        tick();
        checkOutput("reset readdata", readdata, 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        tick();

        readCheck(A_DATA,    32'h0, "rst DATA");
        readCheck(A_IRQMASK, 32'h0, "rst IRQMASK");
        readCheck(A_EDGECAP, 32'h0, "rst EDGECAP");
        readCheck(A_RAW,     32'h0, "rst RAW");
        checkOutput("rst irq", 32'(irq), 32'h0);

        // Steady input: RAW after the synchronizer, DATA after 2+4 clocks
        applyStimulus(5'b00101);
        readCheck(A_RAW,     32'h00, "raw k1");
        readCheck(A_RAW,     32'h00, "raw k2");
        readCheck(A_RAW,     32'h05, "raw k3");
        readCheck(A_DATA,    32'h00, "data k4");
        readCheck(A_DATA,    32'h00, "data k5");
        readCheck(A_DATA,    32'h00, "data k6");
        readCheck(A_DATA,    32'h05, "data k7");
        readCheck(A_EDGECAP, 32'h05, "edgecap k8");
        checkOutput("irq masked", 32'(irq), 32'h0);

        // W1C clear and read-only DATA
        busWrite(A_EDGECAP, 32'h0000_001F);
        readCheck(A_EDGECAP, 32'h0, "edgecap cleared");
        busWrite(A_DATA, 32'h0000_001A);
        readCheck(A_DATA, 32'h05, "data write ignored");

        // Glitches shorter than the debounce window never reach DATA
        for (int p = 0; p < 10; p++) begin
            in_port[0] = (p % 2 == 1);
            for (int c = 0; c < 2; c++) begin
                readCheck(A_DATA, 32'h05, "glitch data");
            end
        end
        applyStimulus(5'b00100);
        readCheck(A_EDGECAP, 32'h0, "glitch edgecap");
        repeat (8) tick();
        readCheck(A_DATA,    32'h04, "fall data");
        readCheck(A_EDGECAP, 32'h01, "fall edgecap");
        busWrite(A_EDGECAP, 32'h0000_001F);

        // Interrupt: masked edge raises irq a clock after EDGECAP, W1C drops it
        busWrite(A_IRQMASK, 32'hFFFF_FFE1);
        readCheck(A_IRQMASK, 32'h01, "irqmask upper bits");
        applyStimulus(5'b00101);
        repeat (6) tick();
        checkOutput("irq same edge as edgecap", 32'(irq), 32'h0);
        tick();
        checkOutput("irq one clk later", 32'(irq), 32'h1);
        readCheck(A_EDGECAP, 32'h01, "irq edgecap");
        busWrite(A_EDGECAP, 32'h0000_0001);
        checkOutput("irq on clear edge", 32'(irq), 32'h1);
        tick();
        checkOutput("irq after clear", 32'(irq), 32'h0);
        readCheck(A_EDGECAP, 32'h0, "edgecap after clear");

        // Set wins over a coincident W1C on bit 2
        applyStimulus(5'b00001);
        repeat (5) tick();
        busWrite(A_EDGECAP, 32'h0000_0004);
        readCheck(A_EDGECAP, 32'h04, "set wins");
        readCheck(A_DATA,    32'h01, "set wins data");
        checkOutput("set wins irq masked", 32'(irq), 32'h0);

        // Reset mid-debounce
        busWrite(A_IRQMASK, 32'h0000_0004);
        tick();
        checkOutput("irq before reset", 32'(irq), 32'h1);
        readCheck(A_DATA, 32'h01, "data before reset");
        applyStimulus(5'b00011);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("async reset readdata", readdata, 32'h0);
        checkOutput("async reset irq", 32'(irq), 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        readCheck(A_DATA,    32'h00, "post reset data k6");
        readCheck(A_DATA,    32'h03, "post reset data k7");
        readCheck(A_EDGECAP, 32'h03, "post reset edgecap");
        readCheck(A_IRQMASK, 32'h00, "post reset irqmask");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nios_2_switch_ctrl

// File: doc/nios_2_switch_ctrl.md
# nios_2_switch_ctrl

Avalon-MM slave that conditions the board's slide-switch inputs for the Nios II processor. Raw switch lines pass through a two-flop synchronizer and a per-bit debounce filter. The block then exposes the debounced level, per-bit edge capture with write-1-to-clear, and a maskable level interrupt. It replaces the bare input PIO on the switch bank and connects to the system interconnect as a 1-wait-free, read-latency-1 slave.

## Interface
- WIDTH, 5, number of switch inputs (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (≥2; 1 ms at 50 MHz)
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active-low; clock clk
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe (write = chipselect & ~write_n)
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  raw asynchronous switch lines
- irq  out  1  active-high level interrupt

## Operation
- Register map (word address):
  - 0 DATA (RO): debounced level, bits [WIDTH-1:0]
  - 1 IRQMASK (RW): per-bit interrupt enable
  - 2 EDGECAP (R/W1C): per-bit captured edge; writing 1 clears that bit; writing 0 has no effect
  - 3 RAW (RO): synchronized undebounced input (sync2)
- Unused upper readdata bits read 0. Writes to addresses 0 and 3 are ignored.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit:
  - if sync2 == stable: cnt <= 0
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0, edge pulse asserted this cycle
  - else: cnt <= cnt+1
  - Any bounce back to the stable value restarts the count from 0.
- Edge capture: both rising and falling edges of stable set EDGECAP[i]. When a set and a W1C clear on the same bit coincide, set wins.
- irq <= |(EDGECAP & IRQMASK), registered. Irq is not cleared by masking alone until the next clock.
- Reset values: readdata 0, irq 0, sync1/sync2 0, stable 0, cnt 0, IRQMASK 0, EDGECAP 0.
- Reset while a switch is held high: after release, a rising edge is debounced and captured normally. This is intended.

## Timing
- Read latency 1: readdata updates on the clock after chipselect & write_n. With no read, readdata holds its last value.
- Write takes effect on the clock edge where write is asserted. A read of the same register on the next cycle returns the new value.
- Latency from in_port to DATA is 2 synchronizer cycles + DEBOUNCE_CYCLES mismatch cycles. EDGECAP sets on the same edge as the stable update, and irq follows one clock later.
- Mid-operation reset clears all state asynchronously. Debounce counts restart from 0.

## Structure
- Package nios_2_switch_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_RAW=3
  - default DEBOUNCE_CYCLES
- Sub-module nios_2_switch_debounce: one bit, containing the synchronizer, counter, stable flop and edge pulse output. It is instantiated WIDTH times via generate.
- Top level holds the register file, the read mux and the irq logic.

## Test plan
Benches use DEBOUNCE_CYCLES=4, WIDTH=5.
- Reset, then read all 4 addresses → all return 0; irq=0.
- Drive in_port=5'b00101 steady → RAW=5'b00101 after 2 clks; DATA=5'b00101 exactly 6 clks after the change; EDGECAP=5'b00101.
- Toggle in_port[0] every 2 clks for 20 clks, then hold 0 → DATA[0] never changes during toggling; no EDGECAP[0] set from the glitches.
- Write IRQMASK=5'b00001, raise in_port[0] → irq=1 one clk after EDGECAP[0] sets; write EDGECAP=1 → irq=0 the following clk.
- Write 1 to EDGECAP[2] on the same clk that bit 2's stable level changes → EDGECAP[2] reads 1 (set wins).
- Assert reset_n=0 mid-debounce with cnt=2 → all outputs 0 immediately. After release, a held input requires the full 2+4 clks to reach DATA.
